serial_rx_align_par: RTL and testbench
======================================

Name: serial_rx_align_par

Overview:
- Parametrised successor to the fixed 8-bit, 4-lane serial receive path of the PHY.
- Runs entirely on the serial bit clock and shifts in one serial bit per cycle.
- Achieves word lock by detecting consecutive comma words (idle symbol, default 8'hBC).
- After lock, emits non-comma words as parallel data with a one-cycle valid pulse, tagged with a round-robin lane index for the downstream lane demux. Declares loss of lock when commas stop arriving.

Parameters:
WIDTH, 8, word width in bits (>=4)
COMMA, 8'hBC, WIDTH-bit idle/alignment symbol
LOCK_COUNT, 4, consecutive aligned commas required to lock (>=1)
NCH, 4, lane count for lane_out rotation (>=1, power of 2 not required)
LOSS_WORDS, 16, consecutive non-comma words before lock is dropped; 0 disables loss detection

Ports:
clk_32f  input  1  serial bit clock; all logic on posedge
reset  input  1  asynchronous, active-low; logic held in reset while 0
data_in  input  1  serial bit, MSB of each word first
data_out  output  WIDTH  last received data word
valid_out  output  1  one-cycle pulse; data_out/lane_out are new this cycle
lane_out  output  max(1,$clog2(NCH))  lane index of data_out
active  output  1  1 while LOCKED
comma_out  output  1  one-cycle pulse on each aligned comma while LOCKED

Behaviour:
- Shift: each edge, sr <= {sr[WIDTH-2:0], data_in}. nxt = the shifted value (combinational). All decisions use nxt, so decisions and outputs register on the edge that samples a word's last bit.
- bit_cnt 0..WIDTH-1; a word boundary occurs when bit_cnt == WIDTH-1 in aligned states.
- Reset (reset==0, asynchronous): state=SEARCH; sr, bit_cnt, comma_cnt, gap_cnt, data_out, lane_out = 0; valid_out, active, comma_out = 0.
- SEARCH:
  - Checks nxt every cycle.
  - nxt==COMMA -> bit_cnt<=0, comma_cnt<=1, go to ALIGN. If LOCK_COUNT==1, go directly to LOCKED.
- ALIGN:
  - bit_cnt increments every cycle.
  - At a boundary, nxt==COMMA -> comma_cnt++. When comma_cnt+1 == LOCK_COUNT -> LOCKED, active<=1, lane_out<=0, gap_cnt<=0.
  - At a boundary, nxt!=COMMA -> comma_cnt<=0, go to SEARCH. The failing word is not re-searched bit-wise on this edge; the search restarts from the next bit.
  - No valid_out in ALIGN.
- LOCKED, at each boundary:
  - nxt==COMMA -> comma_out<=1, gap_cnt<=0, no valid_out.
  - nxt!=COMMA -> data_out<=nxt, valid_out<=1, lane_out<=current lane, gap_cnt++.
  - Lane pointer advances on every boundary, comma or data, wrapping NCH-1 -> 0. The first word after lock is lane 0.
  - LOSS_WORDS!=0 and gap_cnt+1 == LOSS_WORDS on a data word: that word is still emitted. Then state<=SEARCH, active<=0 on the same edge, and comma_cnt, gap_cnt <= 0.
- Between boundaries, valid_out and comma_out are 0 and data_out/lane_out hold their values.
- Latency: the last bit of a word is sampled at edge k; valid_out/data_out are high/valid from edge k to edge k+1.
- Reset asserted mid-word or mid-lock: immediate return to reset values. After release, a full LOCK_COUNT comma sequence is needed again.
- Counter widths: comma_cnt must hold LOCK_COUNT; gap_cnt must hold LOSS_WORDS; bit_cnt must hold WIDTH-1. No overflow is permitted when LOSS_WORDS==0, so gap_cnt saturates.

Test Plan:
- Lock: defaults; reset low 3 cycles, then 4×8'hBC MSB-first with 3 random leading bits -> active rises on the last bit of the 4th comma; no valid_out before that; comma_out 0 during ALIGN.
- Data rotation: after lock, send BC, 8'hFC, 8'hFD, BC, 8'hCA -> valid_out pulses with (FC,lane1), (FD,lane2), (CA,lane0); comma_out pulses for both BC words; each valid pulse is exactly 1 cycle at the word's last bit.
- Broken alignment: 2×BC then 8'h12 at the boundary -> state returns to SEARCH, active stays 0; a subsequent 4×BC locks.
- Loss of lock: LOSS_WORDS=16, after lock send 16 non-comma words 8'h00..8'h0F -> all 16 valid_out pulses occur, active falls on the edge of word 8'h0F; a following word is not emitted.
- Reset mid-operation: assert reset while LOCKED mid-word -> all outputs 0 asynchronously, before the next edge; relock requires 4 fresh commas.
- Param sweep: WIDTH=10, COMMA=10'h17C, NCH=3, LOCK_COUNT=2, LOSS_WORDS=0 -> lock after 2 commas; lane_out cycles 0,1,2,0; 100 data words without commas keep active=1.

Source files
------------

// File: rtl/serial_rx_align_par.sv
// Serial receive path with comma-based word alignment.
// One serial bit is shifted in per clk_32f edge. Consecutive aligned commas
// establish word lock. Once locked, non-comma words are presented in
// parallel with a one-cycle valid pulse and a round-robin lane tag. Lock is
// dropped after a configurable run of data words with no comma.
module serial_rx_align_par #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
    parameter int               LOCK_COUNT = 4,
    parameter int               NCH        = 4,
    parameter int               LOSS_WORDS = 16,
    localparam int              LW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [LW-1:0]    lane_out,
    output logic             active,
    output logic             comma_out
);

    // Counter widths sized to hold their terminal values.
    localparam int BW      = $clog2(WIDTH);
    localparam int CW      = $clog2(LOCK_COUNT + 1);
    localparam int GW      = (LOSS_WORDS > 0) ? $clog2(LOSS_WORDS + 1) : 1;
    localparam int LOSS_M1 = (LOSS_WORDS > 0) ? (LOSS_WORDS - 1) : 0;

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ALIGN,
        S_LOCKED
    } state_t;

    state_t           state_q, state_d;
    // Only the newest WIDTH-1 bits are ever needed: together with data_in
    // they form the full candidate word.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [LW-1:0]    lane_ptr_q, lane_ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic             active_q, active_d;
    logic             comma_q, comma_d;

    logic [WIDTH-1:0] nxt;
    logic             boundary;
    logic             is_comma;
    logic             enter_lock;
    logic [LW-1:0]    lane_inc;

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            gap_cnt_q   <= '0;
            lane_ptr_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            lane_q      <= '0;
            active_q    <= 1'b0;
            comma_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            lane_ptr_q  <= lane_ptr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            active_q    <= active_d;
            comma_q     <= comma_d;
        end
    end

    // Next-state logic: every decision looks at the word completed by this
    // edge's bit, so results register on the edge sampling the last bit.
    always_comb begin
        nxt         = {sr_q, data_in};
        boundary    = (bit_cnt_q == BW'(WIDTH - 1));
        is_comma    = (nxt == COMMA);
        lane_inc    = (lane_ptr_q == LW'(NCH - 1)) ? '0 : lane_ptr_q + 1'b1;
        enter_lock  = 1'b0;

        state_d     = state_q;
        sr_d        = nxt[WIDTH-2:0];
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + 1'b1;
        comma_cnt_d = comma_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        lane_ptr_d  = lane_ptr_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        lane_d      = lane_q;
        active_d    = active_q;
        comma_d     = 1'b0;

        case (state_q)
            S_SEARCH: begin
                // Bit-wise hunt: the comma sets the word phase.
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = CW'(1);
                    if (LOCK_COUNT == 1) begin
                        enter_lock = 1'b1;
                    end else begin
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + 1'b1;
                        if (comma_cnt_q == CW'(LOCK_COUNT - 1)) begin
                            enter_lock = 1'b1;
                        end
                    end else begin
                        // Phase guess was wrong; resume hunting at the next bit.
                        comma_cnt_d = '0;
                        state_d     = S_SEARCH;
                    end
                end
            end
            S_LOCKED: begin
                if (boundary) begin
                    lane_ptr_d = lane_inc;
                    if (is_comma) begin
                        comma_d   = 1'b1;
                        gap_cnt_d = '0;
                    end else begin
                        data_d    = nxt;
                        valid_d   = 1'b1;
                        lane_d    = lane_ptr_q;
                        // Saturate so an unlimited gap (loss disabled) never wraps.
                        gap_cnt_d = (&gap_cnt_q) ? gap_cnt_q : gap_cnt_q + 1'b1;
                        if (LOSS_WORDS != 0 && gap_cnt_q == GW'(LOSS_M1)) begin
                            // The word that exhausts the gap budget is still delivered.
                            state_d     = S_SEARCH;
                            active_d    = 1'b0;
                            comma_cnt_d = '0;
                            gap_cnt_d   = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_SEARCH;
            end
        endcase

        // Common lock entry from SEARCH (single-comma lock) or ALIGN.
        if (enter_lock) begin
            state_d    = S_LOCKED;
            active_d   = 1'b1;
            lane_d     = '0;
            lane_ptr_d = '0;
            gap_cnt_d  = '0;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_out  = lane_q;
    assign active    = active_q;
    assign comma_out = comma_q;

endmodule

// File: tb/tb_serial_rx_align_par.sv
// Directed bench for serial_rx_align_par: default configuration plus a
// WIDTH=10 / NCH=3 / LOCK_COUNT=2 / no-loss-detection variant sharing the
// same serial stream and reset.
module tb_serial_rx_align_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       din;

    logic [7:0] data_a;
    logic       valid_a;
    logic [1:0] lane_a;
    logic       active_a;
    logic       comma_a;

    logic [9:0] data_b;
    logic       valid_b;
    logic [1:0] lane_b;
    logic       active_b;
    logic       comma_b;

    int checks   = 0;
    int failures = 0;
    int mid_a;
    int mid_b;

    serial_rx_align_par dut_a (
        .clk_32f   (clk),
        .reset     (rst_n),
        .data_in   (din),
        .data_out  (data_a),
        .valid_out (valid_a),
        .lane_out  (lane_a),
        .active    (active_a),
        .comma_out (comma_a)
    );

    serial_rx_align_par #(
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .LOCK_COUNT (2),
        .NCH        (3),
        .LOSS_WORDS (0)
    ) dut_b (
        .clk_32f   (clk),
        .reset     (rst_n),
        .data_in   (din),
        .data_out  (data_b),
        .valid_out (valid_b),
        .lane_out  (lane_b),
        .active    (active_b),
        .comma_out (comma_b)
    );

    // Shift nb bits of w out MSB first; returns #1 after the edge that sampled
    // the last bit. Pulses seen on any earlier bit are tallied in mid_a/mid_b.
    task automatic send_bits(input logic [15:0] w, input int nb);
        mid_a = 0;
        mid_b = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            @(negedge clk);
            din = w[i];
            @(posedge clk);
            #1;
            if (i != 0) begin
                if (valid_a || comma_a) mid_a++;
                if (valid_b || comma_b) mid_b++;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (active_a !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", active_a); end
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_a); end
        checks++; if (comma_a !== 1'b0) begin failures++; $display("FAIL reset_comma got=%0b exp=0", comma_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=00", data_a); end
        checks++; if (lane_a !== 2'd0) begin failures++; $display("FAIL reset_lane got=%0d exp=0", lane_a); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        send_bits(16'h0005, 3);  // leading junk 101
        for (int c = 0; c < 3; c++) begin
            send_bits(16'h00BC, 8);
            checks++; if (active_a !== 1'b0) begin failures++; $display("FAIL lock_early_active comma=%0d got=%0b exp=0", c, active_a); end
            checks++; if ((mid_a != 0) || valid_a || comma_a) begin failures++; $display("FAIL lock_align_pulse comma=%0d got=%0d exp=0", c, mid_a + valid_a + comma_a); end
        end
        send_bits(16'h005E, 7);  // first 7 bits of the 4th comma
        checks++; if (active_a !== 1'b0) begin failures++; $display("FAIL lock_before_last_bit got=%0b exp=0", active_a); end
        send_bits(16'h0000, 1);  // last bit of the 4th comma
        checks++; if (active_a !== 1'b1) begin failures++; $display("FAIL lock_rise got=%0b exp=1", active_a); end
        checks++; if (valid_a !== 1'b0 || comma_a !== 1'b0) begin failures++; $display("FAIL lock_edge_pulse got=%0b%0b exp=00", valid_a, comma_a); end
    endtask

    task automatic test_data_rotation();
        logic [7:0] words [5] = '{8'hBC, 8'hFC, 8'hFD, 8'hBC, 8'hCA};
        logic [1:0] lanes [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
        for (int k = 0; k < 5; k++) begin
            send_bits({8'h00, words[k]}, 8);
            checks++; if (mid_a != 0) begin failures++; $display("FAIL rot_mid_pulse word=%0d got=%0d exp=0", k, mid_a); end
            if (words[k] == 8'hBC) begin
                checks++; if (comma_a !== 1'b1 || valid_a !== 1'b0) begin failures++; $display("FAIL rot_comma word=%0d got comma=%0b valid=%0b exp 1/0", k, comma_a, valid_a); end
            end else begin
                checks++; if (valid_a !== 1'b1 || comma_a !== 1'b0) begin failures++; $display("FAIL rot_valid word=%0d got valid=%0b comma=%0b exp 1/0", k, valid_a, comma_a); end
                checks++; if (data_a !== words[k]) begin failures++; $display("FAIL rot_data word=%0d got=%0h exp=%0h", k, data_a, words[k]); end
                checks++; if (lane_a !== lanes[k]) begin failures++; $display("FAIL rot_lane word=%0d got=%0d exp=%0d", k, lane_a, lanes[k]); end
            end
        end
        send_bits(16'h00BC, 8);  // valid from 8'hCA must not linger
        checks++; if (mid_a != 0 || comma_a !== 1'b1) begin failures++; $display("FAIL rot_pulse_width got mid=%0d comma=%0b exp 0/1", mid_a, comma_a); end
    endtask

    task automatic test_broken_alignment();
        apply_reset();
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h0012, 8);
        checks++; if (active_a !== 1'b0 || valid_a !== 1'b0) begin failures++; $display("FAIL broken_no_lock got active=%0b valid=%0b exp 0/0", active_a, valid_a); end
        for (int c = 0; c < 3; c++) send_bits(16'h00BC, 8);
        checks++; if (active_a !== 1'b0) begin failures++; $display("FAIL broken_relock_early got=%0b exp=0", active_a); end
        send_bits(16'h00BC, 8);
        checks++; if (active_a !== 1'b1) begin failures++; $display("FAIL broken_relock got=%0b exp=1", active_a); end
    endtask

    task automatic test_loss_of_lock();
        apply_reset();
        repeat (4) send_bits(16'h00BC, 8);
        checks++; if (active_a !== 1'b1) begin failures++; $display("FAIL loss_lock got=%0b exp=1", active_a); end
        for (int i = 0; i < 16; i++) begin
            send_bits(16'(i), 8);
            checks++; if (valid_a !== 1'b1 || mid_a != 0) begin failures++; $display("FAIL loss_valid word=%0d got valid=%0b mid=%0d exp 1/0", i, valid_a, mid_a); end
            checks++; if (data_a !== 8'(i)) begin failures++; $display("FAIL loss_data word=%0d got=%0h exp=%0h", i, data_a, 8'(i)); end
            checks++; if (lane_a !== 2'(i % 4)) begin failures++; $display("FAIL loss_lane word=%0d got=%0d exp=%0d", i, lane_a, i % 4); end
            checks++; if (active_a !== ((i == 15) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL loss_active word=%0d got=%0b exp=%0b", i, active_a, (i == 15) ? 1'b0 : 1'b1); end
        end
        send_bits(16'h0010, 8);
        checks++; if (valid_a !== 1'b0 || mid_a != 0 || active_a !== 1'b0) begin failures++; $display("FAIL loss_after_drop got valid=%0b mid=%0d active=%0b exp 0/0/0", valid_a, mid_a, active_a); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (4) send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h00FC, 8);
        checks++; if (valid_a !== 1'b1 || data_a !== 8'hFC || lane_a !== 2'd1) begin failures++; $display("FAIL mid_pre got valid=%0b data=%0h lane=%0d exp 1/fc/1", valid_a, data_a, lane_a); end
        send_bits(16'h0005, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (active_a !== 1'b0) begin failures++; $display("FAIL mid_async_active got=%0b exp=0", active_a); end
        checks++; if (data_a !== 8'h00 || lane_a !== 2'd0) begin failures++; $display("FAIL mid_async_data got data=%0h lane=%0d exp 00/0", data_a, lane_a); end
        checks++; if (valid_a !== 1'b0 || comma_a !== 1'b0) begin failures++; $display("FAIL mid_async_pulse got=%0b%0b exp=00", valid_a, comma_a); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) send_bits(16'h00BC, 8);
        checks++; if (active_a !== 1'b0) begin failures++; $display("FAIL mid_relock_early got=%0b exp=0", active_a); end
        send_bits(16'h00BC, 8);
        checks++; if (active_a !== 1'b1) begin failures++; $display("FAIL mid_relock got=%0b exp=1", active_a); end
    endtask

    task automatic test_param_sweep();
        logic [9:0] w;
        apply_reset();
        send_bits(16'h017C, 10);
        checks++; if (active_b !== 1'b0) begin failures++; $display("FAIL sweep_early got=%0b exp=0", active_b); end
        send_bits(16'h017C, 10);
        checks++; if (active_b !== 1'b1) begin failures++; $display("FAIL sweep_lock got=%0b exp=1", active_b); end
        for (int i = 0; i < 100; i++) begin
            w = 10'h200 + 10'(i);
            send_bits({6'd0, w}, 10);
            checks++; if (valid_b !== 1'b1 || mid_b != 0) begin failures++; $display("FAIL sweep_valid word=%0d got valid=%0b mid=%0d exp 1/0", i, valid_b, mid_b); end
            checks++; if (data_b !== w) begin failures++; $display("FAIL sweep_data word=%0d got=%0h exp=%0h", i, data_b, w); end
            checks++; if (lane_b !== 2'(i % 3)) begin failures++; $display("FAIL sweep_lane word=%0d got=%0d exp=%0d", i, lane_b, i % 3); end
        end
        checks++; if (active_b !== 1'b1) begin failures++; $display("FAIL sweep_no_loss got=%0b exp=1", active_b); end
    endtask

    initial begin
        rst_n = 1'b1;
        din   = 1'b0;
        test_reset();
        test_lock();
        test_data_rotation();
        test_broken_alignment();
        test_loss_of_lock();
        test_reset_mid();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
